// File: rtl/wb_arbiter.sv
// Four-master to one-slave Wishbone arbiter with a registered round-robin grant held per cyc burst.
// Optional slave-hang timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [20:1] m0_adr_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [20:1] m1_adr_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  input  logic [15:0] m2_dat_i,
  output logic [15:0] m2_dat_o,
  input  logic [20:1] m2_adr_i,
  input  logic [1:0]  m2_sel_i,
  input  logic        m2_we_i,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  output logic        m2_ack_o,
  input  logic [15:0] m3_dat_i,
  output logic [15:0] m3_dat_o,
  input  logic [20:1] m3_adr_i,
  input  logic [1:0]  m3_sel_i,
  input  logic        m3_we_i,
  input  logic        m3_cyc_i,
  input  logic        m3_stb_i,
  output logic        m3_ack_o,
  input  logic [15:0] s_dat_i,
  output logic [15:0] s_dat_o,
  output logic [20:1] s_adr_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [1:0]  r_last;

  logic [3:0]  w_cyc;
  logic [3:0]  w_stb;
  logic [3:0]  w_we;
  logic [15:0] w_dat [4];
  logic [20:1] w_adr [4];
  logic [1:0]  w_sel [4];
  logic        w_gv;
  logic        w_to;
  logic        w_ack;
  logic [1:0]  w_pick;
  logic [1:0]  w_idx;
  logic        w_any;

  if (TIMEOUT < 8'd2) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT must be in 2..255");
  end

  assign w_cyc = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign w_stb = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign w_we  = {m3_we_i,  m2_we_i,  m1_we_i,  m0_we_i};
  assign w_dat[0] = m0_dat_i;
  assign w_dat[1] = m1_dat_i;
  assign w_dat[2] = m2_dat_i;
  assign w_dat[3] = m3_dat_i;
  assign w_adr[0] = m0_adr_i;
  assign w_adr[1] = m1_adr_i;
  assign w_adr[2] = m2_adr_i;
  assign w_adr[3] = m3_adr_i;
  assign w_sel[0] = m0_sel_i;
  assign w_sel[1] = m1_sel_i;
  assign w_sel[2] = m2_sel_i;
  assign w_sel[3] = m3_sel_i;

  // Round-robin search starts just after the last released master; i=4 wraps back to it.
  always_comb begin
    w_pick = r_last;
    w_idx  = r_last;
    w_any  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_last + i[1:0];
      if (!w_any && w_cyc[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick;
          end
        end
        S_GRANT: begin
          if (!w_cyc[r_gnt]) begin
            r_state <= S_IDLE;
            r_last  <= r_gnt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_to;

  // r_to marks the cycle after the limit is hit: it fakes the ack and suppresses stb.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_to <= 1'b0;
      if (s_stb_o && !s_ack_i) begin
        if (r_cnt == TIMEOUT - 8'd1) begin
          r_to  <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_to = r_to;
`else
  assign w_to = 1'b0;
`endif

  assign w_gv      = (r_state == S_GRANT);
  assign busy_o    = w_gv;
  assign gnt_o     = r_gnt;
  assign timeout_o = w_to;

  assign s_cyc_o = w_gv & w_cyc[r_gnt];
  assign s_stb_o = w_gv & w_cyc[r_gnt] & w_stb[r_gnt] & ~w_to;
  assign s_we_o  = w_gv & w_we[r_gnt];
  assign s_adr_o = w_gv ? w_adr[r_gnt] : '0;
  assign s_sel_o = w_gv ? w_sel[r_gnt] : '0;
  assign s_dat_o = w_gv ? w_dat[r_gnt] : '0;

  assign w_ack    = w_gv & (s_ack_i | w_to);
  assign m0_ack_o = w_ack & (r_gnt == 2'd0);
  assign m1_ack_o = w_ack & (r_gnt == 2'd1);
  assign m2_ack_o = w_ack & (r_gnt == 2'd2);
  assign m3_ack_o = w_ack & (r_gnt == 2'd3);

  assign m0_dat_o = (w_to && r_gnt == 2'd0) ? 16'hFFFF : s_dat_i;
  assign m1_dat_o = (w_to && r_gnt == 2'd1) ? 16'hFFFF : s_dat_i;
  assign m2_dat_o = (w_to && r_gnt == 2'd2) ? 16'hFFFF : s_dat_i;
  assign m3_dat_o = (w_to && r_gnt == 2'd3) ? 16'hFFFF : s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, hand-written corner sequences,
// and randomized traffic against a behavioural round-robin model.
module tb_wb_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mdi [4];
  logic [15:0] mdo [4];
  logic [20:1] madr [4];
  logic [1:0]  msel [4];
  logic [3:0]  mwe, mcyc, mstb;
  logic [3:0]  mack;
  logic [15:0] sdi, sdo;
  logic [20:1] sadr;
  logic [1:0]  ssel;
  logic        swe, scyc, sstb, sack;
  logic [1:0]  gnt;
  logic        busy, tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(8'd4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_dat_i(mdi[0]), .m0_dat_o(mdo[0]), .m0_adr_i(madr[0]), .m0_sel_i(msel[0]),
    .m0_we_i(mwe[0]), .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_ack_o(mack[0]),
    .m1_dat_i(mdi[1]), .m1_dat_o(mdo[1]), .m1_adr_i(madr[1]), .m1_sel_i(msel[1]),
    .m1_we_i(mwe[1]), .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_ack_o(mack[1]),
    .m2_dat_i(mdi[2]), .m2_dat_o(mdo[2]), .m2_adr_i(madr[2]), .m2_sel_i(msel[2]),
    .m2_we_i(mwe[2]), .m2_cyc_i(mcyc[2]), .m2_stb_i(mstb[2]), .m2_ack_o(mack[2]),
    .m3_dat_i(mdi[3]), .m3_dat_o(mdo[3]), .m3_adr_i(madr[3]), .m3_sel_i(msel[3]),
    .m3_we_i(mwe[3]), .m3_cyc_i(mcyc[3]), .m3_stb_i(mstb[3]), .m3_ack_o(mack[3]),
    .s_dat_i(sdi), .s_dat_o(sdo), .s_adr_o(sadr), .s_sel_o(ssel), .s_we_o(swe),
    .s_cyc_o(scyc), .s_stb_o(sstb), .s_ack_i(sack),
    .gnt_o(gnt), .busy_o(busy), .timeout_o(tmo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic       busy;
    logic [1:0] gnt;
    logic       scyc;
    logic       sstb;
    logic [3:0] acks;
  } vec_t;

  function automatic vec_t mk(logic [3:0] c, logic [3:0] s, logic a, logic b,
                              logic [1:0] g, logic sc, logic ss, logic [3:0] ak);
    vec_t v;
    v.cyc = c; v.stb = s; v.ack = a; v.busy = b;
    v.gnt = g; v.scyc = sc; v.sstb = ss; v.acks = ak;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mcyc = '0; mstb = '0; mwe = '0; sack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural model state: gv/g = current owner, last = previous owner.
  int  gv, g, last, tcnt;
  bit  tflag;

  initial begin
    vec_t tbl[$];
    bit   seen;
    rst = 1'b1; mcyc = '0; mstb = '0; mwe = '0; sack = 1'b0; sdi = '0;
    for (int n = 0; n < 4; n++) begin
      mdi[n] = '0; madr[n] = '0; msel[n] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state: nothing granted, ack input must not leak.
    sack = 1'b1;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_scyc_stb", {scyc, sstb}, 0);
    chk("reset_acks", mack, 0);
    chk("reset_timeout", tmo, 0);

    // Master 0 write
    @(negedge clk);
    sack = 1'b0;
    madr[0] = 20'h00100; mdi[0] = 16'hA5A5; msel[0] = 2'b11; mwe[0] = 1'b1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    #2 chk("w0_busy_before", busy, 0);
    @(negedge clk); #2;
    chk("w0_busy", busy, 1);
    chk("w0_bus", {sadr, sdo, ssel, swe, scyc, sstb}, {20'h00100, 16'hA5A5, 2'b11, 1'b1, 1'b1, 1'b1});
    @(negedge clk); sack = 1'b1; #2;
    chk("w0_ack", mack, 4'b0001);
    @(negedge clk); sack = 1'b0; mcyc = '0; mstb = '0; mwe = '0;
    do_reset();

    // Rotation (all four), then burst by m2 with m1 waiting.
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 1, 0, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b1110, 4'b1110, 0, 1, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1110, 4'b1110, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1110, 4'b1110, 1, 1, 1, 1, 1, 4'b0010));
    tbl.push_back(mk(4'b1100, 4'b1100, 0, 1, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1100, 4'b1100, 0, 0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1100, 4'b1100, 1, 1, 2, 1, 1, 4'b0100));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 1, 2, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 0, 2, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 4'b1000, 1, 1, 3, 1, 1, 4'b1000));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 3, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 3, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 0, 3, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 1, 2, 1, 1, 4'b0100));
    tbl.push_back(mk(4'b0110, 4'b0000, 0, 1, 2, 1, 0, 4'b0000));
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 1, 2, 1, 1, 4'b0100));
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 1, 2, 1, 1, 4'b0100));
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 1, 2, 1, 1, 4'b0100));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 2, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 0, 2, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0010, 4'b0010, 1, 1, 1, 1, 1, 4'b0010));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 1, 0, 0, 4'b0000));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      mcyc = tbl[i].cyc; mstb = tbl[i].stb; sack = tbl[i].ack;
      #2;
      chk($sformatf("tbl%0d_busy_gnt", i), {busy, gnt}, {tbl[i].busy, tbl[i].gnt});
      chk($sformatf("tbl%0d_scyc_stb", i), {scyc, sstb}, {tbl[i].scyc, tbl[i].sstb});
      chk($sformatf("tbl%0d_acks", i), mack, tbl[i].acks);
    end

    // Master 3 read: data broadcast, ack only to m3.
    @(negedge clk);
    sack = 1'b0; mcyc = 4'b1000; mstb = 4'b1000; mwe = '0; sdi = 16'h1234;
    @(negedge clk); #2;
    chk("r3_gnt", {busy, gnt}, {1'b1, 2'd3});
    @(negedge clk); sack = 1'b1; #2;
    chk("r3_acks", mack, 4'b1000);
    chk("r3_dat", mdo[3], 16'h1234);
    @(negedge clk); sack = 1'b0; mcyc = '0; mstb = '0;
    do_reset();

    // Reset mid-transfer of m1
    @(negedge clk); mcyc = 4'b0010; mstb = 4'b0010;
    @(negedge clk); #2;
    chk("rm_gnt1", {busy, gnt, sstb}, {1'b1, 2'd1, 1'b1});
    @(negedge clk); rst = 1'b1;
    @(negedge clk); sack = 1'b1; #2;
    chk("rm_after_reset", {scyc, sstb, busy}, 0);
    chk("rm_no_ack", mack, 0);
    @(negedge clk); rst = 1'b0; sack = 1'b0; mcyc = 4'b0011; mstb = 4'b0011;
    @(negedge clk); #2;
    chk("rm_regrant_m0", {busy, gnt}, {1'b1, 2'd0});
    @(negedge clk); mcyc = '0; mstb = '0;
    do_reset();

    // Hung slave on an m0 read
    @(negedge clk); mcyc = 4'b0001; mstb = 4'b0001; mwe = '0; sdi = 16'h0BAD; sack = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      if (k < 5) begin
        chk($sformatf("to_wait%0d", k), {sstb, mack[0], tmo}, 3'b100);
      end else begin
        chk("to_fire", {sstb, mack[0], tmo}, 3'b011);
        chk("to_dat", mdo[0], 16'hFFFF);
      end
    end
    @(negedge clk); #2;
    chk("to_pulse_end", {tmo, mack[0], busy}, 3'b001);
`else
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #2;
      if (mack != 0 || tmo) seen = 1'b1;
    end
    chk("hang_no_ack", {seen, sstb, busy}, 3'b011);
`endif
    @(negedge clk); mcyc = '0; mstb = '0;
    do_reset();

    // Random traffic against model
    gv = 0; g = 0; last = 3; tcnt = 0; tflag = 0;
    for (int c = 0; c < 1500; c++) begin
      logic        estb, eto;
      logic [3:0]  eack;
      logic [63:0] edat;
      logic [40:0] ebus;
      bit          nflag;
      @(negedge clk);
      rst = ($urandom_range(0, 80) == 0);
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 3) == 0) mcyc[n] = ~mcyc[n];
        mstb[n] = ($urandom_range(0, 3) != 0);
        mwe[n]  = $urandom_range(0, 1);
        madr[n] = 20'($urandom);
        msel[n] = 2'($urandom);
        mdi[n]  = 16'($urandom);
      end
      sack = ($urandom_range(0, 3) == 0);
      sdi  = 16'($urandom);
      #2;
      estb = gv != 0 && mcyc[g] && mstb[g] && !tflag;
      eto  = tflag;
      eack = '0;
      edat = {sdi, sdi, sdi, sdi};
      if (gv != 0) begin
        if (sack || tflag) eack[g] = 1'b1;
        if (tflag) edat[g*16 +: 16] = 16'hFFFF;
        ebus = {mcyc[g], estb, mwe[g], msel[g], madr[g], mdi[g]};
      end else begin
        ebus = '0;
      end
      chk("rnd_busy_gnt", {busy, gnt}, {gv != 0, 2'(g)});
      chk("rnd_slave_bus", {scyc, sstb, swe, ssel, sadr, sdo}, ebus);
      chk("rnd_acks", mack, eack);
      chk("rnd_mdat", {mdo[3], mdo[2], mdo[1], mdo[0]}, edat);
      chk("rnd_timeout", tmo, eto);
      if (rst) begin
        gv = 0; g = 0; last = 3; tcnt = 0; tflag = 0;
      end else begin
`ifdef WB_ARB_TIMEOUT_EN
        nflag = estb && !sack && (tcnt == TO - 1);
        tcnt  = (estb && !sack && !nflag) ? tcnt + 1 : 0;
        tflag = nflag;
`else
        nflag = 0;
        tflag = nflag;
`endif
        if (gv == 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (gv == 0 && mcyc[(last + k) % 4]) begin
              g = (last + k) % 4;
              gv = 1;
            end
          end
        end else if (!mcyc[g]) begin
          gv = 0;
          last = g;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Four-master to one-slave Wishbone arbiter; the counterpart of the address-decoding switch, which fans one master out to many slaves.
- Merges CPU, DMA and video/debug masters onto a single shared 16-bit bus. That bus normally feeds the switch's master port.
- Round-robin grant, registered. The grant is held for a whole cycle (cyc) burst.

Parameters:
TIMEOUT, 8'd64, number of cycles s_stb_o may stay high without s_ack_i before a forced termination (used only with WB_ARB_TIMEOUT_EN); legal range 2..255

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  synchronous reset, active high
mN_dat_i  input  16  master N write data (one port for each N=0..3; same for the next 7 lines)
mN_dat_o  output  16  read data to master N
mN_adr_i  input  [20:1]  master N word address
mN_sel_i  input  2  master N byte selects
mN_we_i  input  1  master N write enable
mN_cyc_i  input  1  master N bus request / cycle
mN_stb_i  input  1  master N strobe
mN_ack_o  output  1  ack to master N
s_dat_i  input  16  slave read data
s_dat_o  output  16  write data to slave
s_adr_o  output  [20:1]  address to slave
s_sel_o  output  2  byte selects to slave
s_we_o  output  1  write enable to slave
s_cyc_o  output  1  cycle to slave
s_stb_o  output  1  strobe to slave
s_ack_i  input  1  slave ack
gnt_o  output  2  index of granted master (debug)
busy_o  output  1  grant valid
timeout_o  output  1  one-cycle pulse on forced termination

Behaviour:
- State: gnt_valid (1b), gnt (2b), last (2b). busy_o = gnt_valid, gnt_o = gnt.
- Reset (synchronous, wb_rst_i=1 at the edge): gnt_valid=0, gnt=0, last=3, so master 0 wins first. Timeout counter = 0.
  - Because outputs are combinational from state, s_cyc_o, s_stb_o, all mN_ack_o and timeout_o are 0 after the reset edge.
  - Reset mid-transfer aborts it with no ack.
- IDLE (gnt_valid=0): if any mN_cyc_i=1, search from (last+1) mod 4 upward with wrap. The first requester found becomes gnt; gnt_valid=1 at the next edge. Arbitration latency is 1 cycle.
- GRANTED (gnt_valid=1):
  - s_adr_o, s_sel_o, s_dat_o and s_we_o are muxed combinationally from master gnt.
  - s_cyc_o = m[gnt]_cyc_i; s_stb_o = m[gnt]_cyc_i & m[gnt]_stb_i.
  - When gnt_valid=0, slave-side outputs are 0.
- Ack routing: mN_ack_o = gnt_valid & (gnt==N) & s_ack_i. Non-granted masters never see ack.
- Read data: mN_dat_o = s_dat_i for all N (broadcast); only the acked master samples it.
- Release: when m[gnt]_cyc_i=0 while granted, at that edge gnt_valid←0 and last←gnt.
  - At least one IDLE cycle always occurs between consecutive grants.
- Requests during GRANTED are ignored; there is no preemption. A master that deasserts cyc before being granted is simply not selected.
- Simultaneous requests from all 4 masters, each releasing after 1 transfer: grant order rotates 0,1,2,3,0,...
- stb may toggle within a held cyc (burst of single transfers); the grant persists.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter increments each cycle s_stb_o=1 & s_ack_i=0. It clears on s_ack_i, on s_stb_o=0, and on reset.
  - When the counter reaches TIMEOUT-1 with no ack, the next cycle:
    - m[gnt]_ack_o=1 and m[gnt]_dat_o=16'hFFFF;
    - s_stb_o is forced to 0;
    - timeout_o=1 for exactly 1 cycle;
    - the counter clears.
  - The grant is otherwise unchanged.
- Without the macro: no counter; timeout_o tied to 0; a hung slave stalls the bus indefinitely.

Test Plan:
1. Reset then m0 write (adr 20'h00100, dat 16'hA5A5, sel 2'b11) -> busy_o=1 one cycle after cyc. s_adr_o=20'h00100, s_dat_o=16'hA5A5, s_we_o=1. The s_ack_i pulse appears only on m0_ack_o.
2. m0..m3 all assert cyc on the same cycle, each doing 1 transfer and then dropping cyc -> gnt_o sequence 0,1,2,3, with exactly one IDLE cycle (busy_o=0) between grants.
3. m2 holds cyc for a 4-transfer burst while m1 requests -> gnt_o stays 2 for all 4 acks. m1 is granted only after m2 drops cyc. last=2.
4. m3 read with s_dat_i=16'h1234 -> m3_ack_o=1 and m3_dat_o=16'h1234; m0..m2 ack stay 0.
5. wb_rst_i pulsed while m1 is granted with stb high -> at the reset edge s_cyc_o=0, s_stb_o=0, busy_o=0, no ack. Next request from m1 and m0 together grants m0.
6. (WB_ARB_TIMEOUT_EN, TIMEOUT=4) m0 read, slave never acks -> on the 5th stb cycle: m0_ack_o=1, m0_dat_o=16'hFFFF, timeout_o=1, s_stb_o=0. Without the macro, no ack after 100 cycles.
